// File: rtl/pt_pkg.sv
// Shared constants for the UART-to-pt_enc loader: trit codes, word geometry, RX FSM states.
// The PARITY state only exists when UART_AD_PARITY_EN is defined.
package pt_pkg;

    localparam logic [1:0] TRIT_ZERO  = 2'b00;
    localparam logic [1:0] TRIT_ONE   = 2'b01;
    localparam logic [1:0] TRIT_FLOAT = 2'b10;
    localparam logic [1:0] TRIT_BAD   = 2'b11;

    localparam int AD_WIDTH       = 24;
    localparam int BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_AD_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT
    } rx_state_e;

    function automatic logic has_bad_trit(input logic [AD_WIDTH-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < AD_WIDTH / 2; i++) begin
            if (w[2*i +: 2] == TRIT_BAD) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, down-counting bit timer and RX FSM (UART_AD_PARITY_EN adds 8E1).
// state  | meaning
// IDLE   | line idle, watching for a falling edge
// START  | half a bit in, confirming the start bit
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit (8E1 build only)
// STOP   | sampling the stop bit
// WAIT   | after a framing error, waiting for rx to return high
module uart_rx_byte
    import pt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       start_o,
    output logic       idle_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        valid_o     = 1'b0;
        frame_err_o = 1'b0;
        start_o     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_o = 1'b1;
                    cnt_d   = HALF_LOAD;
                    bit_d   = '0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d   = FULL_LOAD;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
`ifdef UART_AD_PARITY_EN
                    if (bit_q == 3'd7) state_d = RX_PARITY;
`else
                    if (bit_q == 3'd7) state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_AD_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == '0) begin
                    // even parity: data ones plus parity bit must be even
                    if ((^shift_q) ^ rx_sync_q) begin
                        frame_err_o = 1'b1;
                        state_d     = RX_WAIT;
                    end else begin
                        cnt_d   = FULL_LOAD;
                        state_d = RX_STOP;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        valid_o = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_o = 1'b1;
                        state_d     = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o = shift_q;
    assign idle_o = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_ad_loader.sv
// Assembles three UART bytes into the 24-bit pt_enc ad word, checks trits, times ld and the inter-byte gap.
// UART_AD_PARITY_EN selects an 8E1 frame in the byte receiver.
module uart_ad_loader
    import pt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int LD_CYCLES    = 4,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx,
    output logic [AD_WIDTH-1:0] ad,
    output logic                ld,
    output logic                word_ok,
    output logic                frame_err,
    output logic                code_err,
    output logic [1:0]          byte_idx
);

    localparam int            TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW        = $clog2(TO_CYCLES);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TO_CYCLES - 1);
    localparam int            LW        = $clog2(LD_CYCLES + 1);
    localparam logic [LW-1:0] LD_LOAD   = LW'(LD_CYCLES - 1);

    logic rst_meta_q, rst_sync_q;
    logic [7:0] rx_data;
    logic rx_valid, rx_ferr, rx_start, rx_idle;

    logic [AD_WIDTH-1:0] ad_q, ad_d, word;
    logic [15:0]         shadow_q, shadow_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic                ld_q, ld_d, ld_timed_q, ld_timed_d;
    logic [LW-1:0]       ld_cnt_q, ld_cnt_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic                word_ok_q, word_ok_d, code_err_q, code_err_d, frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rst_meta_q, rst_sync_q} <= 2'b00;
        else        {rst_meta_q, rst_sync_q} <= {1'b1, rst_meta_q};
    end

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst_n       (rst_sync_q),
        .rx          (rx),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr),
        .start_o     (rx_start),
        .idle_o      (rx_idle)
    );

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            ad_q        <= '0;
            shadow_q    <= '0;
            byte_idx_q  <= '0;
            ld_q        <= 1'b1;
            ld_timed_q  <= 1'b0;
            ld_cnt_q    <= '0;
            to_cnt_q    <= TO_LOAD;
            word_ok_q   <= 1'b0;
            code_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ad_q        <= ad_d;
            shadow_q    <= shadow_d;
            byte_idx_q  <= byte_idx_d;
            ld_q        <= ld_d;
            ld_timed_q  <= ld_timed_d;
            ld_cnt_q    <= ld_cnt_d;
            to_cnt_q    <= to_cnt_d;
            word_ok_q   <= word_ok_d;
            code_err_q  <= code_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign word = {shadow_q, rx_data};

    always_comb begin
        ad_d        = ad_q;
        shadow_d    = shadow_q;
        byte_idx_d  = byte_idx_q;
        ld_d        = ld_q;
        ld_timed_d  = ld_timed_q;
        ld_cnt_d    = ld_cnt_q;
        to_cnt_d    = to_cnt_q;
        word_ok_d   = 1'b0;
        code_err_d  = 1'b0;
        frame_err_d = 1'b0;

        // ld after reset has no timer: it is held until the first good word
        if (ld_timed_q) begin
            if (ld_cnt_q == '0) begin
                ld_d       = 1'b0;
                ld_timed_d = 1'b0;
            end else begin
                ld_cnt_d = ld_cnt_q - 1'b1;
            end
        end

        if (byte_idx_q == 2'd0 || !rx_idle || rx_start) begin
            to_cnt_d = TO_LOAD;
        end else if (to_cnt_q == '0) begin
            byte_idx_d = 2'd0;
        end else begin
            to_cnt_d = to_cnt_q - 1'b1;
        end

        if (rx_ferr) begin
            frame_err_d = 1'b1;
            byte_idx_d  = 2'd0;
        end

        if (rx_valid) begin
            case (byte_idx_q)
                2'd0: begin
                    shadow_d[15:8] = rx_data;
                    byte_idx_d     = 2'd1;
                end
                2'd1: begin
                    shadow_d[7:0] = rx_data;
                    byte_idx_d    = 2'd2;
                end
                default: begin
                    byte_idx_d = 2'd0;
                    if (has_bad_trit(word)) begin
                        code_err_d = 1'b1;
                    end else begin
                        ad_d       = word;
                        word_ok_d  = 1'b1;
                        ld_d       = 1'b1;
                        ld_timed_d = 1'b1;
                        ld_cnt_d   = LD_LOAD;
                    end
                end
            endcase
        end
    end

    assign ad        = ad_q;
    assign ld        = ld_q;
    assign word_ok   = word_ok_q;
    assign code_err  = code_err_q;
    assign frame_err = frame_err_q;
    assign byte_idx  = byte_idx_q;

endmodule
